// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Shares one multi-cycle sequential divider among NREQ
//               requesters. Round-robin grant, operand latching, divider
//               start/done sequencing, per-requester result return and a
//               hang watchdog on the divider.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid[NREQ]          request per requester, held with operands until ready
//   req_dividend/divisor     packed operands, requester i at [i*W +: W]
//   req_ready[NREQ]          one-hot 1-cycle accept pulse
//   rsp_valid[NREQ]          one-hot 1-cycle result pulse to the owner
//   rsp_quotient/remainder   result, held until the next delivery
//   rsp_id                   owner of the current/last result
//   rsp_err                  1 = watchdog abort (or divide-by-zero bypass)
//   busy                     high whenever the arbiter is not idle
//   div_enable               1-cycle start pulse to the divider
//   div_dividend/divisor     latched operands presented to the divider
//   div_done, div_quotient,
//   div_remainder            divider completion pulse and result
// Build option
//   DIV_ZERO_BYPASS_EN       when defined, a zero divisor is answered locally
//                            (Q=all-ones, R=dividend, err=1) without using
//                            the divider.
// ============================================================================
module div_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_quotient,
    output logic [W-1:0]      rsp_remainder,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic              busy,
    output logic              div_enable,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    input  logic              div_done,
    input  logic [W-1:0]      div_quotient,
    input  logic [W-1:0]      div_remainder
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_DELIVER = 2'd3;

    localparam int              c_WDW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  c_LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW:0]    c_NREQ_X   = (IDW+1)'(NREQ);
    localparam logic [NREQ-1:0] c_ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_gnt;
    logic [c_WDW-1:0] r_wd_cnt;
    logic [W-1:0]     r_res_q;
    logic [W-1:0]     r_res_r;
    logic             r_res_err;

    logic [NREQ-1:0]  r_req_ready;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [W-1:0]     r_rsp_quotient;
    logic [W-1:0]     r_rsp_remainder;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_err;
    logic             r_busy;
    logic             r_div_enable;
    logic [W-1:0]     r_div_dividend;
    logic [W-1:0]     r_div_divisor;

    logic             w_gnt_found;
    logic [IDW-1:0]   w_gnt;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_pick;
    logic [W-1:0]     w_sel_dividend;
    logic [W-1:0]     w_sel_divisor;

    // Round-robin search starting at r_rr_ptr. Walking the offsets from the
    // farthest to the nearest lets the nearest requesting index win.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt       = '0;
        w_sum       = '0;
        w_pick      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= c_NREQ_X) begin
                w_pick = IDW'(w_sum - c_NREQ_X);
            end else begin
                w_pick = IDW'(w_sum);
            end
            if (req_valid[w_pick]) begin
                w_gnt       = w_pick;
                w_gnt_found = 1'b1;
            end
        end
    end

    assign w_sel_dividend = req_dividend[int'(w_gnt)*W +: W];
    assign w_sel_divisor  = req_divisor[int'(w_gnt)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_rr_ptr        <= '0;
            r_gnt           <= '0;
            r_wd_cnt        <= '0;
            r_res_q         <= '0;
            r_res_r         <= '0;
            r_res_err       <= 1'b0;
            r_req_ready     <= '0;
            r_rsp_valid     <= '0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_id        <= '0;
            r_rsp_err       <= 1'b0;
            r_busy          <= 1'b0;
            r_div_enable    <= 1'b0;
            r_div_dividend  <= '0;
            r_div_divisor   <= '0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_div_enable <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_gnt_found) begin
                        r_gnt          <= w_gnt;
                        r_req_ready    <= c_ONE << w_gnt;
                        r_div_dividend <= w_sel_dividend;
                        r_div_divisor  <= w_sel_divisor;
                        r_busy         <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                        if (w_sel_divisor == '0) begin
                            r_res_q   <= '1;
                            r_res_r   <= w_sel_dividend;
                            r_res_err <= 1'b1;
                            r_state   <= c_ST_DELIVER;
                        end else begin
                            r_state <= c_ST_ISSUE;
                        end
`else
                        r_state <= c_ST_ISSUE;
`endif
                    end
                end

                c_ST_ISSUE: begin
                    r_div_enable <= 1'b1;
                    r_wd_cnt     <= '0;
                    r_state      <= c_ST_WAIT;
                end

                c_ST_WAIT: begin
                    // A completion in the last allowed cycle still counts as success.
                    if (div_done) begin
                        r_res_q   <= div_quotient;
                        r_res_r   <= div_remainder;
                        r_res_err <= 1'b0;
                        r_state   <= c_ST_DELIVER;
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        r_res_q   <= '1;
                        r_res_r   <= '0;
                        r_res_err <= 1'b1;
                        r_state   <= c_ST_DELIVER;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                c_ST_DELIVER: begin
                    r_rsp_valid     <= c_ONE << r_gnt;
                    r_rsp_id        <= r_gnt;
                    r_rsp_quotient  <= r_res_q;
                    r_rsp_remainder <= r_res_r;
                    r_rsp_err       <= r_res_err;
                    r_rr_ptr        <= (r_gnt == c_LAST_ID) ? '0 : r_gnt + 1'b1;
                    r_busy          <= 1'b0;
                    r_state         <= c_ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_id        = r_rsp_id;
    assign rsp_err       = r_rsp_err;
    assign busy          = r_busy;
    assign div_enable    = r_div_enable;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;

endmodule
`default_nettype wire
